// File: rtl/plab4_net_router_input_terminal_queue_2dom.sv
// Terminal-port input buffer: one domain-tagged inbound stream split into two independent FIFOs.
// Define PLAB4_NET_TERMINAL_QUEUE_BYPASS_EN to let a message skip an empty FIFO in the same cycle.
module plab4_net_router_input_terminal_queue_2dom #(
  parameter int  p_router_id      = 0,
  parameter int  p_num_routers    = 8,
  parameter int  p_msg_nbits      = 44,
  parameter int  p_num_entries    = 2,
  parameter int  p_num_free_nbits = 2,
  localparam int c_dest_nbits     = $clog2(p_num_routers)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_val,
  output logic                        in_rdy,
  input  logic                        in_domain,
  input  logic [p_msg_nbits-1:0]      in_msg,
  output logic                        out_val_d0,
  input  logic                        out_rdy_d0,
  output logic [p_msg_nbits-1:0]      out_msg_d0,
  output logic [c_dest_nbits-1:0]     dest_d0,
  output logic [p_num_free_nbits-1:0] num_free_d0,
  output logic                        out_val_d1,
  input  logic                        out_rdy_d1,
  output logic [p_msg_nbits-1:0]      out_msg_d1,
  output logic [c_dest_nbits-1:0]     dest_d1,
  output logic [p_num_free_nbits-1:0] num_free_d1
);

  localparam int c_addr_nbits = $clog2(p_num_entries);
  localparam int c_cnt_nbits  = c_addr_nbits + 1;
  localparam int c_free_max   = (1 << p_num_free_nbits) - 1;

  if (p_num_entries < 2 || (p_num_entries & (p_num_entries - 1)) != 0) begin : g_bad_entries
    $error("p_num_entries must be a power of two >= 2");
  end
  if (p_router_id < 0 || p_router_id >= p_num_routers) begin : g_bad_router_id
    $error("p_router_id out of range");
  end

  function automatic logic [p_num_free_nbits-1:0] sat_free(input logic [c_cnt_nbits-1:0] cnt);
    int free;
    free = p_num_entries - int'(cnt);
    if (free > c_free_max) free = c_free_max;
    return p_num_free_nbits'(free);
  endfunction

  logic [1:0]                             out_rdy_v;
  logic [1:0]                             val_v;
  logic [1:0]                             full_v;
  logic [1:0][p_msg_nbits-1:0]            msg_v;
  logic [1:0][c_dest_nbits-1:0]           dest_v;
  logic [1:0][p_num_free_nbits-1:0]       free_v;

  assign out_rdy_v = {out_rdy_d1, out_rdy_d0};

  for (genvar d = 0; d < 2; d++) begin : g_dom
    logic [c_addr_nbits-1:0] rd_ptr;
    logic [c_addr_nbits-1:0] wr_ptr;
    logic [c_cnt_nbits-1:0]  count;
    logic [p_msg_nbits-1:0]  mem [p_num_entries];
    logic [p_msg_nbits-1:0]  head_msg;
    logic                    sel;
    logic                    empty;
    logic                    full;
    logic                    enq;
    logic                    deq;
    logic                    head_val;

    assign sel   = in_val && (in_domain == (d != 0));
    assign empty = (count == '0);
    assign full  = (count == c_cnt_nbits'(p_num_entries));
    assign deq   = !empty && out_rdy_v[d];

`ifdef PLAB4_NET_TERMINAL_QUEUE_BYPASS_EN
    logic bypass;
    // A message consumed straight through the bypass never touches storage.
    assign bypass   = empty && sel;
    assign head_val = !empty || bypass;
    assign head_msg = empty ? in_msg : mem[rd_ptr];
    assign enq      = sel && !full && !(bypass && out_rdy_v[d]);
`else
    assign head_val = !empty;
    assign head_msg = mem[rd_ptr];
    assign enq      = sel && !full;
`endif

    always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr] <= in_msg;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + 1'b1;
        if (deq) rd_ptr <= rd_ptr + 1'b1;
        if (enq && !deq)      count <= count + 1'b1;
        else if (deq && !enq) count <= count - 1'b1;
      end
    end

    // Destination is masked while empty so stale entries never reach the controller.
    assign val_v[d]  = head_val;
    assign msg_v[d]  = head_msg;
    assign dest_v[d] = head_val ? head_msg[p_msg_nbits-1 -: c_dest_nbits] : '0;
    assign free_v[d] = sat_free(count);
    assign full_v[d] = full;
  end

  assign in_rdy      = !full_v[in_domain];

  assign out_val_d0  = val_v[0];
  assign out_msg_d0  = msg_v[0];
  assign dest_d0     = dest_v[0];
  assign num_free_d0 = free_v[0];
  assign out_val_d1  = val_v[1];
  assign out_msg_d1  = msg_v[1];
  assign dest_d1     = dest_v[1];
  assign num_free_d1 = free_v[1];

endmodule

// File: tb/tb_plab4_net_router_input_terminal_queue_2dom.sv
// Scoreboard bench for the two-domain terminal input queue; reference is a pair of message queues.
`timescale 1ns/1ps
module tb_plab4_net_router_input_terminal_queue_2dom;

  localparam int MW   = 44;
  localparam int DW   = 3;
  localparam int N    = 2;
  localparam int FMAX = 3;
`ifdef PLAB4_NET_TERMINAL_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_val = 1'b0;
  logic          in_domain = 1'b0;
  logic [MW-1:0] in_msg = '0;
  logic          out_rdy_d0 = 1'b0;
  logic          out_rdy_d1 = 1'b0;
  logic          in_rdy;
  logic          out_val_d0, out_val_d1;
  logic [MW-1:0] out_msg_d0, out_msg_d1;
  logic [DW-1:0] dest_d0, dest_d1;
  logic [1:0]    num_free_d0, num_free_d1;

  plab4_net_router_input_terminal_queue_2dom #(
    .p_router_id(0), .p_num_routers(8), .p_msg_nbits(MW), .p_num_entries(N), .p_num_free_nbits(2)
  ) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_domain(in_domain), .in_msg(in_msg),
    .out_val_d0(out_val_d0), .out_rdy_d0(out_rdy_d0), .out_msg_d0(out_msg_d0), .dest_d0(dest_d0),
    .num_free_d0(num_free_d0),
    .out_val_d1(out_val_d1), .out_rdy_d1(out_rdy_d1), .out_msg_d1(out_msg_d1), .dest_d1(dest_d1),
    .num_free_d1(num_free_d1)
  );

  always #5 clk = ~clk;

  logic [1:0]    ov_v, ordy_v;
  logic [MW-1:0] om_v [2];
  logic [DW-1:0] dst_v [2];
  logic [1:0]    nf_v [2];
  assign ov_v   = {out_val_d1, out_val_d0};
  assign ordy_v = {out_rdy_d1, out_rdy_d0};
  assign om_v[0] = out_msg_d0;
  assign om_v[1] = out_msg_d1;
  assign dst_v[0] = dest_d0;
  assign dst_v[1] = dest_d1;
  assign nf_v[0] = num_free_d0;
  assign nf_v[1] = num_free_d1;

  int            checks = 0;
  int            errors = 0;
  logic [MW-1:0] sb [2][$];
  logic          acc_pend = 1'b0;
  logic          acc_dom = 1'b0;
  logic [MW-1:0] acc_msg = '0;
  logic          taken = 1'b0;

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus: decide acceptance from the reference occupancy before the edge.
  task automatic drive(input bit v, input bit dom, input logic [MW-1:0] m, input bit r0, input bit r1);
    int sz;
    @(negedge clk);
    in_val = v; in_domain = dom; in_msg = m; out_rdy_d0 = r0; out_rdy_d1 = r1;
    sz = sb[dom].size();
    taken    = v && (sz < N);
    acc_pend = taken && !(BYP && sz == 0 && (dom ? r1 : r0));
    acc_dom  = dom;
    acc_msg  = m;
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset && acc_pend) sb[acc_dom].push_back(acc_msg);
  end

  task automatic mon_cycle();
    bit exp_rdy;
    exp_rdy = sb[in_domain].size() < N;
    chk("in_rdy", MW'(in_rdy), MW'(exp_rdy));
    for (int d = 0; d < 2; d++) begin
      int            cnt;
      int            ef;
      bit            byp;
      logic [MW-1:0] head;
      cnt = sb[d].size();
      byp = BYP && cnt == 0 && in_val && (int'(in_domain) == d);
      chk($sformatf("out_val_d%0d", d), MW'(ov_v[d]), MW'(cnt != 0 || byp));
      ef = N - cnt;
      if (ef > FMAX) ef = FMAX;
      chk($sformatf("num_free_d%0d", d), MW'(nf_v[d]), MW'(ef));
      if (cnt != 0 || byp) begin
        head = byp ? in_msg : sb[d][0];
        chk($sformatf("out_msg_d%0d", d), om_v[d], head);
        chk($sformatf("dest_d%0d", d), MW'(dst_v[d]), MW'(head[MW-1 -: DW]));
        if (ordy_v[d] && cnt != 0) void'(sb[d].pop_front());
      end else begin
        chk($sformatf("dest_d%0d_masked", d), MW'(dst_v[d]), '0);
      end
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!reset) mon_cycle();
  end

  function automatic logic [MW-1:0] rmsg();
    return MW'({$urandom(), $urandom()});
  endfunction

  initial begin
    int k;
    int cyc;
    #1;
    chk("rst out_val_d0", MW'(out_val_d0), '0);
    chk("rst out_val_d1", MW'(out_val_d1), '0);
    chk("rst num_free_d0", MW'(num_free_d0), MW'(2));
    chk("rst num_free_d1", MW'(num_free_d1), MW'(2));
    chk("rst in_rdy", MW'(in_rdy), MW'(1));
    chk("rst dest_d1", MW'(dest_d1), '0);
    @(negedge clk);
    reset = 1'b0;

    // Fill d0, probe in_rdy for both domains, then reset with two messages queued.
    drive(1, 0, 44'hA1, 0, 0);
    drive(1, 0, 44'hA2, 0, 0);
    drive(0, 0, '0, 0, 0);
    drive(0, 1, '0, 0, 0);
    drive(1, 0, 44'hA3, 0, 0);
    drive(0, 0, '0, 0, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst out_val_d0", MW'(out_val_d0), '0);
    chk("midrst num_free_d0", MW'(num_free_d0), MW'(2));
    chk("midrst in_rdy", MW'(in_rdy), MW'(1));
    chk("midrst dest_d0", MW'(dest_d0), '0);
    sb[0].delete();
    sb[1].delete();
    acc_pend = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drive(0, 0, '0, 1, 1);
    drive(0, 0, '0, 1, 1);

    // Order and wrap on d1 with a toggling pop request.
    k = 1; cyc = 0;
    while (k <= 5 && cyc < 50) begin
      drive(1, 1, {3'(k), 41'(k * 41'h1111)}, 0, cyc[0]);
      if (taken) k++;
      cyc++;
    end
    chk("order all_sent", MW'(k), MW'(6));
    repeat (4) drive(0, 1, '0, 0, 1);

    // Simultaneous enqueue and dequeue on d0 with one entry held.
    drive(1, 0, 44'h8_0000_0000_B1, 0, 0);
    drive(1, 0, 44'h6_0000_0000_B2, 1, 0);
    drive(0, 0, '0, 0, 0);
    repeat (2) drive(0, 0, '0, 1, 0);

    // d0 held full while d1 streams one message per cycle.
    drive(1, 0, rmsg(), 0, 0);
    drive(1, 0, rmsg(), 0, 0);
    repeat (10) drive(1, 1, rmsg(), 0, 1);
    repeat (2) drive(0, 1, '0, 0, 1);
    chk("iso num_free_d0", MW'(num_free_d0), '0);
    repeat (2) drive(0, 0, '0, 1, 0);

    // Randomized traffic.
    repeat (3000) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom()), rmsg(),
            $urandom_range(0, 4) < 3, $urandom_range(0, 4) < 3);
    end
    repeat (4) drive(0, 0, '0, 1, 1);
    @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/plab4_net_router_input_terminal_queue_2dom.md
# plab4_net_router_input_terminal_queue_2dom

Two-domain input buffer for a router's terminal (injection) port, placed directly upstream of the terminal input controller/arbiter. One domain-tagged inbound message stream is split into two independent per-domain FIFOs. Each FIFO presents its head message's valid bit and destination field to the controller, and pops when the controller asserts the matching ready. Per-domain free-entry counts are exported for flow control toward the injecting terminal.

## Interface
- p_router_id, 0, router index; informational only, not used in datapath
- p_num_routers, 8, number of routers; sets c_dest_nbits = $clog2(p_num_routers)
- p_msg_nbits, 44, message width; dest field is msg[p_msg_nbits-1 -: c_dest_nbits]
- p_num_entries, 2, entries per domain FIFO; power of two, ≥2
- p_num_free_nbits, 2, width of free counts; saturates at 2^p_num_free_nbits-1
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- in_val  input  1  inbound message valid
- in_rdy  output  1  inbound ready: !full of the FIFO selected by in_domain
- in_domain  input  1  domain tag of inbound message (0 or 1)
- in_msg  input  p_msg_nbits  inbound message
- out_val_d0 / out_val_d1  output  1  FIFO head valid, per domain
- out_rdy_d0 / out_rdy_d1  input  1  pop request from controller, per domain
- out_msg_d0 / out_msg_d1  output  p_msg_nbits  head message, per domain
- dest_d0 / dest_d1  output  c_dest_nbits  dest field of head message, per domain
- num_free_d0 / num_free_d1  output  p_num_free_nbits  free entries, per domain, saturated

## Operation
- Enqueue: in_val && in_rdy writes in_msg into the FIFO selected by in_domain. The other FIFO is untouched.
- in_rdy depends only on the selected FIFO's full flag, never on out_rdy, so there is no combinational path from out_rdy to in_rdy. A full FIFO refuses enqueue even in a cycle where it pops.
- Dequeue: out_val_dX && out_rdy_dX advances domain X's read pointer. out_rdy_dX while empty is ignored.
- Each FIFO has read and write pointers of $clog2(p_num_entries) bits that wrap modulo p_num_entries, plus a count register of $clog2(p_num_entries)+1 bits.
- Count update per cycle: +1 on enq only, -1 on deq only, unchanged on simultaneous enq and deq (legal only when not full).
- out_val_dX = (count_X != 0). out_msg_dX and dest_dX come from the head entry. dest_dX is zero when empty (masked), so the controller never sees stale destinations.
- num_free_dX = min(p_num_entries - count_X, 2^p_num_free_nbits - 1).
- The domains are fully independent. No state, pointer or count of one domain depends on the other domain's traffic, except through the shared in_rdy/in_domain input port.
- An inbound message with in_val=0 never changes state, regardless of in_domain.

## Timing
- Reset (async assert) clears all pointers and counts immediately. While reset is high: out_val_d0/d1=0, dest_d0/d1=0, num_free = saturated p_num_entries, in_rdy=1. Storage contents are not reset. Reset mid-operation discards all queued messages.
- Without bypass: a message enqueued at edge N is visible on out_* after edge N (1-cycle latency). An enqueue and a pop in the same cycle both take effect at the same edge.
- in_rdy is combinational from in_domain and registered counts only.
- Full→not-full: a pop at edge N makes in_rdy=1 for that domain after edge N.

## Configuration
- PLAB4_NET_TERMINAL_QUEUE_BYPASS_EN defined: when domain X's FIFO is empty and in_val && in_domain==X, out_val_dX=1 and out_msg_dX/dest_dX=in_msg in the same cycle. If out_rdy_dX is also high, the message is consumed without being written and the count stays 0. Otherwise the message is enqueued normally.
- Not defined: no combinational in_* to out_* path; the 1-cycle minimum latency applies.

## Test plan
- Reset: assert reset mid-stream with 2 msgs queued in d0 → out_val_d0=0, num_free_d0=2, in_rdy=1 immediately; no message appears after deassert.
- Fill d0: inject 0xA1, 0xA2 (in_domain=0, out_rdy_d0=0) → in_rdy=0 for domain 0, in_rdy=1 when in_domain=1, num_free_d0=0, num_free_d1=2.
- FIFO order and wrap: push 5 msgs to d1 with out_rdy_d1 toggling → popped in order 1..5; dest_d1 matches the top c_dest_nbits bits of each message.
- Simultaneous enq/deq with count=1 on d0 → count stays 1, head advances, num_free_d0=1.
- Domain isolation: hold d0 full for 10 cycles while streaming d1 at one msg per cycle with out_rdy_d1=1 → d1 throughput 1/cycle, d0 state unchanged.
- Bypass (macro on): empty d1, in_val=1, in_domain=1, out_rdy_d1=1 → out_val_d1=1 the same cycle, num_free_d1 stays 2. With the macro off, out_val_d1 first rises the next cycle.
